// File: rtl/multi_channel_timer_if.sv
// multi_channel_timer_if: control/status bundle between register decode and the timer
interface multi_channel_timer_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
);
  logic [PSC_W-1:0]      prescale;
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH-1:0]       mode;
  logic [N_CH*WIDTH-1:0] period;
  logic [N_CH-1:0]       irq_clr;
  logic [N_CH*WIDTH-1:0] counter;
  logic [N_CH-1:0]       running;
  logic [N_CH-1:0]       irq_pending;
  logic [N_CH-1:0]       overrun;
  logic                  irq;
  modport master (
    output prescale, start, stop, mode, period, irq_clr,
    input  counter, running, irq_pending, overrun, irq
  );
  modport slave (
    input  prescale, start, stop, mode, period, irq_clr,
    output counter, running, irq_pending, overrun, irq
  );
endinterface

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: N-channel one-shot/periodic timer with shared prescaler and sticky irqs
module multi_channel_timer #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input logic clk,
  input logic rst,
  multi_channel_timer_if.slave bus
);
  logic [PSC_W-1:0] r_pc;
  logic             w_tick;
  logic [N_CH-1:0]  w_pend;
  logic             r_irq;
  // >= lets a lowered prescale take effect immediately instead of after a wrap
  assign w_tick = r_pc >= bus.prescale;
  // free-running prescaler shared by all channels
  always_ff @(posedge clk)
    if (!rst) r_pc <= '0;
    else r_pc <= w_tick ? '0 : r_pc + PSC_W'(1);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_per;
    logic             r_mode;
    logic             r_run;
    logic             r_pend;
    logic             r_ovr;
    logic             w_tc;
    // stop and start both pre-empt a terminal count on the same cycle
    assign w_tc = r_run && w_tick && (r_cnt == r_per) && !bus.stop[i] && !bus.start[i];
    // per-channel counter, shadow registers and sticky flags
    always_ff @(posedge clk)
      if (!rst) begin
        r_cnt  <= '0;
        r_per  <= '0;
        r_mode <= 1'b0;
        r_run  <= 1'b0;
        r_pend <= 1'b0;
        r_ovr  <= 1'b0;
      end else begin
        if (bus.stop[i]) r_run <= 1'b0;
        else if (bus.start[i]) begin
          r_run  <= 1'b1;
          r_cnt  <= '0;
          r_per  <= bus.period[i*WIDTH +: WIDTH];
          r_mode <= bus.mode[i];
        end else if (w_tc) begin
          r_run <= r_mode;
          if (r_mode) begin
            r_cnt  <= '0;
            r_per  <= bus.period[i*WIDTH +: WIDTH];
            r_mode <= bus.mode[i];
          end
        end else if (r_run && w_tick) r_cnt <= r_cnt + WIDTH'(1);
        r_pend <= w_tc | (r_pend & ~bus.irq_clr[i]);
        r_ovr  <= w_tc ? (r_ovr | (r_pend & ~bus.irq_clr[i])) : (r_ovr & ~bus.irq_clr[i]);
      end
    assign bus.counter[i*WIDTH +: WIDTH] = r_cnt;
    assign bus.running[i]                = r_run;
    assign bus.overrun[i]                = r_ovr;
    assign w_pend[i]                     = r_pend;
  end
  // combined interrupt, registered so it lags the pending flags by one cycle
  always_ff @(posedge clk)
    if (!rst) r_irq <= 1'b0;
    else r_irq <= |w_pend;
  assign bus.irq_pending = w_pend;
  assign bus.irq         = r_irq;
endmodule

// File: tb/tb_multi_channel_timer.sv
// tb_multi_channel_timer: table-driven scoreboard bench for multi_channel_timer
module tb_multi_channel_timer;
  localparam int N = 4;
  localparam int W = 16;
  localparam int P = 8;
  localparam logic [3:0]  Z   = 4'h0;
  localparam logic [63:0] Z64 = 64'd0;
  logic clk = 1'b0;
  logic rst = 1'b0;
  multi_channel_timer_if #(.N_CH(N), .WIDTH(W), .PSC_W(P)) bus ();
  multi_channel_timer #(.N_CH(N), .WIDTH(W), .PSC_W(P)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic        r;
    logic [7:0]  psc;
    logic [3:0]  st, sp, md, clr;
    logic [63:0] per;
    logic [63:0] cnt;
    logic [3:0]  run, pend, ovr;
    logic        irq;
  } vec_t;
  typedef struct {
    logic [63:0] cnt;
    logic [3:0]  run, pend, ovr;
    logic        irq;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic add(input logic r, input logic [7:0] psc, input logic [3:0] st, sp, md,
                     input logic [63:0] per, input logic [3:0] clr, input logic [63:0] cnt,
                     input logic [3:0] run, pend, ovr, input logic irq);
    vec_t v;
    v.r = r; v.psc = psc; v.st = st; v.sp = sp; v.md = md; v.per = per; v.clr = clr;
    v.cnt = cnt; v.run = run; v.pend = pend; v.ovr = ovr; v.irq = irq;
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, req);
    end
  endtask
  initial begin
    logic [63:0] pb, pc1, pd, pe0, pe9, pf, c;
    logic [3:0]  pn, on;
    int          t, n;
    int          fp[4];
    fp = '{1, 2, 3, 4};
    pb  = 64'd5;
    pc1 = {16'd0, 16'd0, 16'd2, 16'd0};
    pd  = {16'd1, 16'd3, 16'd0, 16'd1};
    pe0 = 64'd0;
    pe9 = 64'd9;
    pf  = {16'd4, 16'd3, 16'd2, 16'd1};
    // reset state
    add(1'b0, 8'd0, Z, Z, Z, Z64, Z, Z64, Z, Z, Z, 1'b0);
    add(1'b0, 8'd0, Z, Z, Z, Z64, Z, Z64, Z, Z, Z, 1'b0);
    // one-shot ch0, period 5
    add(1'b1, 8'd0, 4'h1, Z, Z, pb, Z, Z64, 4'h1, Z, Z, 1'b0);
    for (int k = 1; k <= 5; k++) add(1'b1, 8'd0, Z, Z, Z, pb, Z, 64'(k), 4'h1, Z, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, Z, pb, Z, 64'd5, Z, 4'h1, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, Z, pb, Z, 64'd5, Z, 4'h1, Z, 1'b1);
    add(1'b1, 8'd0, Z, Z, Z, pb, 4'h1, 64'd5, Z, Z, Z, 1'b1);
    add(1'b1, 8'd0, Z, Z, Z, pb, Z, 64'd5, Z, Z, Z, 1'b0);
    // reset mid-count
    add(1'b1, 8'd0, 4'h1, Z, Z, pb, Z, Z64, 4'h1, Z, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, Z, pb, Z, 64'd1, 4'h1, Z, Z, 1'b0);
    add(1'b0, 8'd0, Z, Z, Z, pb, Z, Z64, Z, Z, Z, 1'b0);
    // periodic ch1, period 2, prescale 3: one tick every 4 cycles, wrap every 12
    for (int k = 0; k <= 27; k++) begin
      t = (k + 1) / 4;
      add(1'b1, 8'd3, (k == 0) ? 4'h2 : Z, Z, 4'h2, pc1, Z, {16'd0, 16'd0, 16'(t % 3), 16'd0},
          4'h2, (t >= 3) ? 4'h2 : Z, (t >= 6) ? 4'h2 : Z, k >= 12);
    end
    add(1'b1, 8'd3, Z, 4'h2, 4'h2, pc1, Z, 64'h0000_0000_0001_0000, Z, 4'h2, 4'h2, 1'b1);
    for (int k = 0; k < 4; k++)
      add(1'b1, 8'd3, Z, Z, 4'h2, pc1, Z, 64'h0000_0000_0001_0000, Z, 4'h2, 4'h2, 1'b1);
    add(1'b1, 8'd3, Z, Z, 4'h2, pc1, 4'h2, 64'h0000_0000_0001_0000, Z, Z, Z, 1'b1);
    add(1'b1, 8'd3, Z, Z, 4'h2, pc1, Z, 64'h0000_0000_0001_0000, Z, Z, Z, 1'b0);
    // races
    add(1'b0, 8'd0, Z, Z, Z, Z64, Z, Z64, Z, Z, Z, 1'b0);
    add(1'b1, 8'd0, 4'h1, Z, Z, pd, Z, Z64, 4'h1, Z, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, Z, pd, Z, 64'd1, 4'h1, Z, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, Z, pd, 4'h1, 64'd1, Z, 4'h1, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, Z, pd, Z, 64'd1, Z, 4'h1, Z, 1'b1);
    add(1'b1, 8'd0, 4'h4, 4'h4, Z, pd, Z, 64'd1, Z, 4'h1, Z, 1'b1);
    add(1'b1, 8'd0, Z, Z, Z, pd, Z, 64'd1, Z, 4'h1, Z, 1'b1);
    add(1'b1, 8'd0, 4'h8, Z, Z, pd, Z, 64'd1, 4'h8, 4'h1, Z, 1'b1);
    add(1'b1, 8'd0, Z, Z, Z, pd, Z, 64'h0001_0000_0000_0001, 4'h8, 4'h1, Z, 1'b1);
    add(1'b1, 8'd0, Z, 4'h8, Z, pd, Z, 64'h0001_0000_0000_0001, Z, 4'h1, Z, 1'b1);
    add(1'b1, 8'd0, Z, Z, Z, pd, Z, 64'h0001_0000_0000_0001, Z, 4'h1, Z, 1'b1);
    // period 0 periodic, then period 9 picked up on the next wrap
    add(1'b0, 8'd0, Z, Z, Z, Z64, Z, Z64, Z, Z, Z, 1'b0);
    add(1'b1, 8'd0, 4'h1, Z, 4'h1, pe0, Z, Z64, 4'h1, Z, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, 4'h1, pe0, Z, Z64, 4'h1, 4'h1, Z, 1'b0);
    add(1'b1, 8'd0, Z, Z, 4'h1, pe9, Z, Z64, 4'h1, 4'h1, 4'h1, 1'b1);
    for (int k = 1; k <= 9; k++) add(1'b1, 8'd0, Z, Z, 4'h1, pe9, Z, 64'(k), 4'h1, 4'h1, 4'h1, 1'b1);
    add(1'b1, 8'd0, Z, Z, 4'h1, pe9, Z, Z64, 4'h1, 4'h1, 4'h1, 1'b1);
    // all channels periodic with periods 1..4
    add(1'b0, 8'd0, Z, Z, Z, Z64, Z, Z64, Z, Z, Z, 1'b0);
    add(1'b1, 8'd0, 4'hF, Z, 4'hF, pf, Z, Z64, 4'hF, Z, Z, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      c = '0; pn = '0; on = '0;
      for (int i = 0; i < 4; i++) begin
        c[i*16 +: 16] = 16'(k % (fp[i] + 1));
        pn[i] = k >= fp[i] + 1;
        on[i] = k >= 2 * (fp[i] + 1);
      end
      add(1'b1, 8'd0, Z, Z, 4'hF, pf, Z, c, 4'hF, pn, on, k >= 3);
    end
    // apply the table through the scoreboard
    for (int n2 = 0; n2 < tbl.size(); n2++) begin
      vec_t v;
      exp_t e;
      exp_t g;
      v = tbl[n2];
      rst = v.r; bus.prescale = v.psc; bus.start = v.st; bus.stop = v.sp;
      bus.mode = v.md; bus.period = v.per; bus.irq_clr = v.clr;
      e.cnt = v.cnt; e.run = v.run; e.pend = v.pend; e.ovr = v.ovr; e.irq = v.irq;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard vec %0d: got empty want entry", n2);
      end else begin
        g = sb.pop_front();
        chk("counter", n2, bus.counter, g.cnt);
        chk("running", n2, 64'(bus.running), 64'(g.run));
        chk("irq_pending", n2, 64'(bus.irq_pending), 64'(g.pend));
        chk("overrun", n2, 64'(bus.overrun), 64'(g.ovr));
        chk("irq", n2, 64'(bus.irq), 64'(g.irq));
      end
    end
    // hand-written latency sequence: one-shot ch2, period 5, prescale 0
    rst = 1'b0; bus.start = Z; bus.stop = Z; bus.irq_clr = Z;
    @(posedge clk);
    #1;
    rst = 1'b1; bus.prescale = 8'd0; bus.mode = Z; bus.period = {16'd0, 16'd5, 16'd0, 16'd0};
    bus.start = 4'h4;
    @(posedge clk);
    #1;
    bus.start = Z;
    n = 0;
    while (!bus.irq_pending[2] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 0, 64'(n), 64'd6);
    chk("lat_counter", 0, 64'(bus.counter[32 +: 16]), 64'd5);
    chk("lat_running", 0, 64'(bus.running), 64'd0);
    chk("lat_irq_lag", 0, 64'(bus.irq), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_irq", 0, 64'(bus.irq), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
